// File: rtl/clk_div_prog.sv
// Multi-channel programmable clock divider: each channel toggles s_clk every act+1 enabled cycles.
// Define CLKDIV_TICK_EN to build the per-channel wrap tick registers; otherwise tick is tied to 0.
module clk_div_prog #(
  parameter int NCH     = 2,
  parameter int CNT_W   = 12,
  parameter int DIV_RST = 2267
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             sync,
  input  logic [NCH-1:0]   div_ld,
  input  logic [CNT_W-1:0] div_in,
  output logic [NCH-1:0]   s_clk,
  output logic [NCH-1:0]   tick
);

  localparam logic [CNT_W-1:0] DIV_RST_V = CNT_W'(DIV_RST);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] act;
    logic [CNT_W-1:0] shd;
    logic             pending;
    logic             s_clk_r;
    logic             wrap;

    // act only changes at a wrap or a sync, so cnt can never run past it.
    assign wrap     = (cnt == act);
    assign s_clk[i] = s_clk_r;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt     <= '0;
        act     <= DIV_RST_V;
        shd     <= DIV_RST_V;
        pending <= 1'b0;
        s_clk_r <= 1'b0;
      end else if (sync) begin
        cnt     <= '0;
        s_clk_r <= 1'b0;
        pending <= 1'b0;
        if (div_ld[i]) begin
          act <= div_in;
          shd <= div_in;
        end else if (pending) begin
          act <= shd;
        end
      end else begin
        if (div_ld[i]) begin
          shd <= div_in;
        end
        if (en && wrap) begin
          cnt     <= '0;
          s_clk_r <= ~s_clk_r;
          pending <= 1'b0;
          // A load landing exactly on the wrap edge goes straight to act.
          if (div_ld[i]) begin
            act <= div_in;
          end else if (pending) begin
            act <= shd;
          end
        end else begin
          if (en) begin
            cnt <= cnt + 1'b1;
          end
          if (div_ld[i]) begin
            pending <= 1'b1;
          end
        end
      end
    end

`ifdef CLKDIV_TICK_EN
    logic tick_r;
    assign tick[i] = tick_r;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        tick_r <= 1'b0;
      end else if (sync || !en) begin
        tick_r <= 1'b0;
      end else begin
        tick_r <= wrap;
      end
    end
`endif
  end : g_ch

`ifndef CLKDIV_TICK_EN
  assign tick = '0;
`endif

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog (NCH=2, CNT_W=12, DIV_RST=2267); inputs change and outputs are read on negedge.
module tb_clk_div_prog;

`ifdef CLKDIV_TICK_EN
  localparam bit TICK_ON = 1'b1;
`else
  localparam bit TICK_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic        sync = 1'b0;
  logic [1:0]  div_ld = '0;
  logic [11:0] div_in = '0;
  logic [1:0]  s_clk;
  logic [1:0]  tick;

  int n_total = 0;
  int n_pass  = 0;
  int n;

  clk_div_prog #(.NCH(2), .CNT_W(12), .DIV_RST(2267)) dut (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .sync   (sync),
    .div_ld (div_ld),
    .div_in (div_in),
    .s_clk  (s_clk),
    .tick   (tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic logic [1:0] tk(input logic [1:0] v);
    return TICK_ON ? v : 2'b00;
  endfunction

  // Count rising edges until s_clk[ch] changes; returns at the following negedge.
  task automatic wait_toggle(input int ch, input int budget, output int cycles);
    logic prev;
    prev = s_clk[ch];
    cycles = 0;
    while (cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (s_clk[ch] !== prev) return;
    end
    cycles = -1;
  endtask

  initial begin
    // Reset state, asynchronous before any clock edge.
    #1;
    check("reset_s_clk", s_clk, 0);
    check("reset_tick", tick, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_s_clk", s_clk, 0);
    check("idle_tick", tick, 0);

    // Default divisor: first rise 2268 enabled edges in, half period 2268.
    en = 1'b1;
    wait_toggle(0, 3000, n);
    check("first_rise_cycles", n, 2268);
    check("first_rise_s_clk", s_clk, 2'b11);
    check("first_wrap_tick", tick, tk(2'b11));
    @(negedge clk);
    check("tick_one_cycle", tick, 0);
    wait_toggle(0, 3000, n);
    check("first_fall_cycles", n, 2267);
    check("first_fall_s_clk", s_clk, 2'b00);

    // Load ch1 with 4 at cnt=100: current half period finishes first.
    repeat (100) @(negedge clk);
    div_ld = 2'b10;
    div_in = 12'd4;
    @(negedge clk);
    div_ld = 2'b00;
    wait_toggle(1, 3000, n);
    check("ch1_finish_half", n + 1, 2168);
    check("ch1_finish_s_clk", s_clk, 2'b11);
    wait_toggle(1, 100, n);
    check("ch1_half_a", n, 5);
    wait_toggle(1, 100, n);
    check("ch1_half_b", n, 5);
    wait_toggle(0, 3000, n);
    check("ch0_unaffected", n, 2258);

    // Sync with coincident loads of 9 on both channels.
    div_ld = 2'b11;
    div_in = 12'd9;
    sync   = 1'b1;
    @(negedge clk);
    div_ld = 2'b00;
    sync   = 1'b0;
    check("sync9_s_clk", s_clk, 2'b00);
    check("sync9_tick", tick, 0);
    wait_toggle(0, 100, n);
    check("act9_half", n, 10);

    // Freeze for 10 cycles at cnt=3; a load into ch1 during the freeze waits for its wrap.
    repeat (3) @(negedge clk);
    en     = 1'b0;
    div_ld = 2'b10;
    div_in = 12'd2;
    @(negedge clk);
    div_ld = 2'b00;
    repeat (9) @(negedge clk);
    check("freeze_s_clk", s_clk, 2'b11);
    check("freeze_tick", tick, 0);
    en = 1'b1;
    wait_toggle(0, 100, n);
    check("after_freeze_cycles", n, 7);
    check("after_freeze_s_clk", s_clk, 2'b00);
    wait_toggle(1, 100, n);
    check("ch1_shadow_applied", n, 3);

    // Last load wins, then sync aligns act0=3 and act1=7.
    div_ld = 2'b01;
    div_in = 12'd5;
    @(negedge clk);
    div_in = 12'd3;
    @(negedge clk);
    div_ld = 2'b10;
    div_in = 12'd7;
    @(negedge clk);
    div_ld = 2'b00;
    sync   = 1'b1;
    @(negedge clk);
    sync = 1'b0;
    check("sync_align_s_clk", s_clk, 2'b00);
    wait_toggle(0, 100, n);
    check("align_ch0_cycles", n, 4);
    check("align_ch0_s_clk", s_clk, 2'b01);
    check("align_ch0_tick", tick, tk(2'b01));
    wait_toggle(1, 100, n);
    check("align_ch1_cycles", n, 4);
    check("align_ch1_s_clk", s_clk, 2'b10);
    check("align_both_tick", tick, tk(2'b11));

    // Divisor 0 on ch0: toggle every cycle, tick held high.
    div_ld = 2'b01;
    div_in = 12'd0;
    sync   = 1'b1;
    @(negedge clk);
    div_ld = 2'b00;
    sync   = 1'b0;
    check("div0_sync_s_clk", s_clk[0], 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("div0_s_clk", s_clk[0], (k % 2 == 0) ? 1 : 0);
      check("div0_tick", tick[0], TICK_ON);
    end

    // Load coinciding with a wrap edge takes effect at that edge.
    div_ld = 2'b01;
    div_in = 12'd1;
    @(negedge clk);
    div_ld = 2'b00;
    wait_toggle(0, 100, n);
    check("coincident_half_a", n, 2);
    wait_toggle(0, 100, n);
    check("coincident_half_b", n, 2);

    // Asynchronous reset between edges while s_clk[0]=1.
    for (int k = 0; k < 4 && s_clk[0] !== 1'b1; k++) @(negedge clk);
    check("pre_reset_s_clk0", s_clk[0], 1);
    #1 reset = 1'b1;
    #1;
    check("async_reset_s_clk", s_clk, 0);
    check("async_reset_tick", tick, 0);
    @(negedge clk);
    reset = 1'b0;
    wait_toggle(0, 3000, n);
    check("post_reset_rise", n, 2268);
    check("post_reset_s_clk", s_clk, 2'b11);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
